vscale_mem_arbiter: RTL and testbench

Two-requester arbiter that shares one pipelined single-port memory between the core's instruction port (imem) and data port (dmem). It sits between the core and the memory/bus bridge. Each cycle it grants at most one address phase and tracks the following data phase, stretching it on `mem_wait`. It steers read data, error, and wait signals back to the owning requester.

---
 rtl/vscale_mem_arbiter_if.sv | 47 ++++
 rtl/vscale_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_vscale_mem_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/vscale_mem_arbiter_if.sv
// Bus bundle between the core's imem/dmem ports, the arbiter and the shared
// pipelined single-port memory. The arbiter uses the slave modport; the
// environment (core + memory) uses the master modport.
interface vscale_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction port
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_wait;
  logic              imem_badmem_e;
  // Data port
  logic              dmem_en;
  logic              dmem_wen;
  logic [2:0]        dmem_size;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata_delayed;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_wait;
  logic              dmem_badmem_e;
  // Shared memory port
  logic              mem_en;
  logic              mem_wen;
  logic [2:0]        mem_size;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_wait;
  logic              mem_badmem_e;

  modport slave (
    input  imem_addr, dmem_en, dmem_wen, dmem_size, dmem_addr,
           dmem_wdata_delayed, mem_rdata, mem_wait, mem_badmem_e,
    output imem_rdata, imem_wait, imem_badmem_e,
           dmem_rdata, dmem_wait, dmem_badmem_e,
           mem_en, mem_wen, mem_size, mem_addr, mem_wdata
  );

  modport master (
    output imem_addr, dmem_en, dmem_wen, dmem_size, dmem_addr,
           dmem_wdata_delayed, mem_rdata, mem_wait, mem_badmem_e,
    input  imem_rdata, imem_wait, imem_badmem_e,
           dmem_rdata, dmem_wait, dmem_badmem_e,
           mem_en, mem_wen, mem_size, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vscale_mem_arbiter.sv
// Two-requester arbiter sharing one pipelined single-port memory between the
// core's fetch (imem) and data (dmem) ports. At most one address phase is
// granted per cycle; the following data phase is tracked by the state register
// and stretched by mem_wait. Read data, error and wait are steered back to the
// owner of the data phase.
// Optional feature: define VSCALE_ARB_ROUND_ROBIN_EN to alternate the grant
// between the two requesters under contention (default: dmem always wins,
// since its access belongs to the older instruction).
module vscale_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  vscale_mem_arbiter_if.slave      bus
);

  localparam logic [2:0] SIZE_WORD = 3'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA_I = 2'd1,
    DATA_D = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              wen_q, wen_d;
  logic              ipend_q, dpend_q;
  logic              ireq, dreq, accept, prio_d;
  logic              grant_i, grant_d;
  logic              i_done, d_done;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  // A fetch is always requested outside reset; reset suppresses both requests
  // so no address phase leaks out while it is high.
  assign ireq   = !reset;
  assign dreq   = bus.dmem_en && !reset;
  // A new address phase can only overlap a data phase that is completing.
  assign accept = (state_q == IDLE) || !bus.mem_wait;

`ifdef VSCALE_ARB_ROUND_ROBIN_EN
  logic last_d_q;

  assign prio_d = !last_d_q;

  // Remember who won the last grant so contention alternates.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_d_q <= 1'b0;
    end else if (grant_i || grant_d) begin
      last_d_q <= grant_d;
    end
  end
`else
  assign prio_d = 1'b1;
`endif

  assign grant_d = accept && dreq && (!ireq || prio_d);
  assign grant_i = accept && ireq && !grant_d;

  // Next data-phase owner: hold while stretched, else follow the grant.
  always_comb begin
    state_d = state_q;
    wen_d   = wen_q;
    if (!((state_q != IDLE) && bus.mem_wait)) begin
      if (grant_d) begin
        state_d = DATA_D;
        wen_d   = bus.dmem_wen;
      end else if (grant_i) begin
        state_d = DATA_I;
        wen_d   = 1'b0;
      end else begin
        state_d = IDLE;
        wen_d   = 1'b0;
      end
    end
  end

  // Data-phase owner and registered requests; ipend_q resets high so the core
  // sees imem_wait during reset and the first cycle after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wen_q   <= 1'b0;
      ipend_q <= 1'b1;
      dpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wen_q   <= wen_d;
      ipend_q <= ireq;
      dpend_q <= dreq;
    end
  end

  // Address-phase steering from the granted requester; zero when idle.
  always_comb begin
    bus.mem_en   = grant_i || grant_d;
    bus.mem_wen  = 1'b0;
    bus.mem_size = 3'd0;
    addr_sel     = '0;
    if (grant_d) begin
      bus.mem_wen  = bus.dmem_wen;
      bus.mem_size = bus.dmem_size;
      addr_sel     = bus.dmem_addr;
    end else if (grant_i) begin
      bus.mem_size = SIZE_WORD;
      addr_sel     = bus.imem_addr;
    end
  end

  assign bus.mem_addr = addr_sel;

  // Data-phase completion per owner.
  assign i_done = (state_q == DATA_I) && !bus.mem_wait;
  assign d_done = (state_q == DATA_D) && !bus.mem_wait;

  assign wdata_sel     = ((state_q == DATA_D) && wen_q) ? bus.dmem_wdata_delayed : '0;
  assign bus.mem_wdata = wdata_sel;

  assign bus.imem_rdata    = bus.mem_rdata;
  assign bus.dmem_rdata    = bus.mem_rdata;
  assign bus.imem_wait     = ipend_q && !i_done;
  assign bus.dmem_wait     = dpend_q && !d_done;
  assign bus.imem_badmem_e = i_done && bus.mem_badmem_e;
  assign bus.dmem_badmem_e = d_done && bus.mem_badmem_e;

endmodule

// File: tb/tb_vscale_mem_arbiter.sv
// Testbench for vscale_mem_arbiter: a per-cycle vector table (stimulus plus
// hand-derived expected outputs) drives the arbiter; each driven vector's
// expectations are queued and checked on the falling edge of the same cycle.
module tb_vscale_mem_arbiter;

`ifdef VSCALE_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic reset;

  vscale_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  vscale_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        den;
    logic        dwen;
    logic [2:0]  dsz;
    logic [31:0] daddr;
    logic [31:0] iaddr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mwait;
    logic        mbad;
    logic        e_en;
    logic        e_wen;
    logic [2:0]  e_size;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_iw;
    logic        e_dw;
    logic        e_ib;
    logic        e_db;
    string       name;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   tests  = 0;
  int   failed = 0;

  function automatic vec_t v(
    input int unsigned rst, den, dwen, dsz, daddr, iaddr, wdata, mwait, mbad,
    input int unsigned e_en, e_wen, e_size, e_addr, e_wdata, e_iw, e_dw, e_ib, e_db,
    input string name
  );
    vec_t r;
    r.rst     = (rst != 0);
    r.den     = (den != 0);
    r.dwen    = (dwen != 0);
    r.dsz     = 3'(dsz);
    r.daddr   = 32'(daddr);
    r.iaddr   = 32'(iaddr);
    r.wdata   = 32'(wdata);
    r.rdata   = 32'd0;
    r.mwait   = (mwait != 0);
    r.mbad    = (mbad != 0);
    r.e_en    = (e_en != 0);
    r.e_wen   = (e_wen != 0);
    r.e_size  = 3'(e_size);
    r.e_addr  = 32'(e_addr);
    r.e_wdata = 32'(e_wdata);
    r.e_iw    = (e_iw != 0);
    r.e_dw    = (e_dw != 0);
    r.e_ib    = (e_ib != 0);
    r.e_db    = (e_db != 0);
    r.name    = name;
    return r;
  endfunction

  task automatic chk(input string row, input string sig, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s.%s: got %h, expected %h", row, sig, act, exp);
    end
  endtask

  // Compare the DUT against the queued expectation for the current cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      vec_t e;
      e = exp_q.pop_front();
      chk(e.name, "mem_en",        32'(bus.mem_en),        32'(e.e_en));
      chk(e.name, "mem_wen",       32'(bus.mem_wen),       32'(e.e_wen));
      chk(e.name, "mem_size",      32'(bus.mem_size),      32'(e.e_size));
      chk(e.name, "mem_addr",      bus.mem_addr,           e.e_addr);
      chk(e.name, "mem_wdata",     bus.mem_wdata,          e.e_wdata);
      chk(e.name, "imem_wait",     32'(bus.imem_wait),     32'(e.e_iw));
      chk(e.name, "dmem_wait",     32'(bus.dmem_wait),     32'(e.e_dw));
      chk(e.name, "imem_badmem_e", 32'(bus.imem_badmem_e), 32'(e.e_ib));
      chk(e.name, "dmem_badmem_e", 32'(bus.dmem_badmem_e), 32'(e.e_db));
      chk(e.name, "imem_rdata",    bus.imem_rdata,         e.rdata);
      chk(e.name, "dmem_rdata",    bus.dmem_rdata,         e.rdata);
    end
  end

  initial begin
    reset                  = 1'b1;
    bus.imem_addr          = '0;
    bus.dmem_en            = 1'b0;
    bus.dmem_wen           = 1'b0;
    bus.dmem_size          = 3'd0;
    bus.dmem_addr          = '0;
    bus.dmem_wdata_delayed = '0;
    bus.mem_rdata          = '0;
    bus.mem_wait           = 1'b0;
    bus.mem_badmem_e       = 1'b0;

    // rst den dwen dsz daddr iaddr wdata mwait mbad | en wen size addr wdata iw dw ib db
    // Reset state; badmem/mem_wait driven to show they are masked.
    vecs.push_back(v(1,0,0,0,0,'h0,0,0,1,            0,0,0,0,0,1,0,0,0, "reset_a"));
    vecs.push_back(v(1,0,0,0,0,'h0,0,1,0,            0,0,0,0,0,1,0,0,0, "reset_b"));
    // Reset release: fetch stream 0x0, 0x4, 0x8.
    vecs.push_back(v(0,0,0,0,0,'h0,0,0,0,            1,0,2,'h0,0,1,0,0,0, "fetch0"));
    vecs.push_back(v(0,0,0,0,0,'h4,0,0,0,            1,0,2,'h4,0,0,0,0,0, "fetch4"));
    vecs.push_back(v(0,0,0,0,0,'h8,0,0,0,            1,0,2,'h8,0,0,0,0,0, "fetch8"));
    // Load 0x100 contends with fetch 0x20: dmem first, fetch one cycle later.
    vecs.push_back(v(0,1,0,1,'h100,'h20,0,0,0,       1,0,1,'h100,0,0,0,0,0, "ld_contend"));
    vecs.push_back(v(0,0,0,0,0,'h20,0,0,0,           1,0,2,'h20,0,1,0,0,0, "ld_done"));
    vecs.push_back(v(0,0,0,0,0,'h24,0,0,0,           1,0,2,'h24,0,0,0,0,0, "f20_done"));
    // Store 0xDEADBEEF to 0x200 stretched by two mem_wait cycles.
    vecs.push_back(v(0,1,1,2,'h200,'h28,'hDEADBEEF,0,0, 1,1,2,'h200,0,0,0,0,0, "st_addr"));
    vecs.push_back(v(0,1,1,2,'h200,'h28,'hDEADBEEF,1,1, 0,0,0,0,'hDEADBEEF,1,1,0,0, "st_wait1"));
    vecs.push_back(v(0,1,1,2,'h200,'h28,'hDEADBEEF,1,0, 0,0,0,0,'hDEADBEEF,1,1,0,0, "st_wait2"));
    vecs.push_back(v(0,0,0,0,0,'h28,'hDEADBEEF,0,0,  1,0,2,'h28,'hDEADBEEF,1,0,0,0, "st_done"));
    // Error on a fetch data phase: only imem sees it, one cycle.
    vecs.push_back(v(0,0,0,0,0,'h2C,'h12345678,0,1,  1,0,2,'h2C,0,0,0,1,0, "fetch_err"));
    vecs.push_back(v(0,0,0,0,0,'h30,0,0,0,           1,0,2,'h30,0,0,0,0,0, "err_clear"));
    // Reset during a stretched DATA_D phase.
    vecs.push_back(v(0,1,0,2,'h300,'h34,0,0,0,       1,0,2,'h300,0,0,0,0,0, "ld2_addr"));
    vecs.push_back(v(0,1,0,2,'h300,'h34,0,1,0,       0,0,0,0,0,1,1,0,0, "ld2_wait"));
    vecs.push_back(v(1,1,0,2,'h300,'h34,0,1,0,       0,0,0,0,0,1,1,0,0, "rst_mid"));
    vecs.push_back(v(1,1,0,2,'h300,'h34,0,1,1,       0,0,0,0,0,1,0,0,0, "rst_idle"));
    vecs.push_back(v(0,0,0,0,0,'h0,0,0,0,            1,0,2,'h0,0,1,0,0,0, "rst_refetch"));
    // Both requesting for four cycles: D,D,D,D fixed; D,I,D,I round robin.
    vecs.push_back(v(0,1,0,2,'h400,'h4,0,0,0,        1,0,2,'h400,0,0,0,0,0, "both1"));
    vecs.push_back(v(0,1,0,2,'h400,'h4,0,0,0,        1,0,2,(RR ? 'h4 : 'h400),0,1,0,0,0, "both2"));
    vecs.push_back(v(0,1,0,2,'h400,'h4,0,0,0,        1,0,2,'h400,0,(RR ? 0 : 1),(RR ? 1 : 0),0,0, "both3"));
    vecs.push_back(v(0,1,0,2,'h400,'h4,0,0,0,        1,0,2,(RR ? 'h4 : 'h400),0,1,0,0,0, "both4"));
    vecs.push_back(v(0,0,0,0,0,'h8,0,0,0,            1,0,2,'h8,0,(RR ? 0 : 1),(RR ? 1 : 0),0,0, "both_end"));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t c;
      c = vecs[i];
      c.rdata = 32'hA5A50000 | 32'(i);
      @(posedge clk);
      #1;
      reset                  = c.rst;
      bus.dmem_en            = c.den;
      bus.dmem_wen           = c.dwen;
      bus.dmem_size          = c.dsz;
      bus.dmem_addr          = c.daddr;
      bus.imem_addr          = c.iaddr;
      bus.dmem_wdata_delayed = c.wdata;
      bus.mem_rdata          = c.rdata;
      bus.mem_wait           = c.mwait;
      bus.mem_badmem_e       = c.mbad;
      exp_q.push_back(c);
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
